// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for the multicycle ARM-subset datapath. A Moore FSM steps each
// instruction through 2 to 5 cycles. The block also holds the NZCV flag
// register and gates every architectural write (PC, register file, memory)
// with the instruction's condition field.
//
// Configuration macro:
//   MCCTRL_CMP_EN - when defined, cmd 1010 (CMP) decodes as SUB with the
//                   register write suppressed. Flags are still updated when
//                   S=1. When undefined, cmd 1010 is treated like any other
//                   unsupported cmd: ADD with the write suppressed.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   Cond       in   [3:0] Instr[31:28] condition field
//   Op         in   [1:0] Instr[27:26] instruction class
//   Funct      in   [5:0] Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (memory: L)
//   Rd         in   [3:0] Instr[15:12] destination register
//   ALUFlags   in   [3:0] {N,Z,C,V} produced by the ALU this cycle
//   PCWrite    out  PC register enable
//   AdrSrc     out  memory address select: 0=PC, 1=ALUOut register
//   MemWrite   out  data memory write enable
//   IRWrite    out  instruction register enable
//   RegWrite   out  register file write enable
//   ResultSrc  out  [1:0] 00=ALUOut reg, 01=Data reg, 10=ALU direct
//   ALUSrcA    out  0=RD1 reg, 1=PC
//   ALUSrcB    out  [1:0] 00=RD2 reg, 01=ExtImm, 10=constant 4
//   ALUControl out  [2:0] 000 ADD, 001 SUB, 010 AND, 011 ORR
//   ImmSrc     out  [1:0] immediate format, equal to Op
//   RegSrc     out  [1:0] register read-address selects
//   State      out  [3:0] current state encoding (debug only)
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  state_t     state_q, state_d;
  logic [3:0] flags_q;          // {N,Z,C,V}
  logic       condex_q;         // condition result, held for the rest of the instruction
  logic       cond_ex;          // condition result, evaluated live against flags_q
  logic [2:0] dp_alu_op;        // ALU op decoded from cmd
  logic       no_write;         // cmd must not write the register file
  logic       flag_we;
  logic       cv_we;
  logic       pc_dest;

  // ---------------------------------------------------------------------------
  // Condition evaluation. The result only matters in DECODE, where it is
  // latched. Every later state uses condex_q, so the outputs never depend
  // combinationally on ALUFlags.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;                    // EQ
      4'b0001: cond_ex = ~z;                   // NE
      4'b0010: cond_ex = c;                    // CS
      4'b0011: cond_ex = ~c;                   // CC
      4'b0100: cond_ex = n;                    // MI
      4'b0101: cond_ex = ~n;                   // PL
      4'b0110: cond_ex = v;                    // VS
      4'b0111: cond_ex = ~v;                   // VC
      4'b1000: cond_ex = c & ~z;               // HI
      4'b1001: cond_ex = ~c | z;               // LS
      4'b1010: cond_ex = (n == v);             // GE
      4'b1011: cond_ex = (n != v);             // LT
      4'b1100: cond_ex = ~z & (n == v);        // GT
      4'b1101: cond_ex = z | (n != v);         // LE
      4'b1110: cond_ex = 1'b1;                 // AL
      default: cond_ex = 1'b0;                 // 1111: never executes
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data-processing decode. An unsupported cmd still runs the ALU as an ADD so
  // the datapath sees a defined operation, but its result is never written.
  // ---------------------------------------------------------------------------
  always_comb begin
    dp_alu_op = ALU_ADD;
    no_write  = 1'b0;
    case (Funct[4:1])
      4'b0100: dp_alu_op = ALU_ADD;
      4'b0010: dp_alu_op = ALU_SUB;
      4'b0000: dp_alu_op = ALU_AND;
      4'b1100: dp_alu_op = ALU_ORR;
`ifdef MCCTRL_CMP_EN
      4'b1010: begin                           // CMP: subtract, flags only
        dp_alu_op = ALU_SUB;
        no_write  = 1'b1;
      end
`endif
      default: begin
        dp_alu_op = ALU_ADD;
        no_write  = 1'b1;
      end
    endcase
  end

  // Flags load at the end of an execute state when S is set and the
  // instruction passed its condition. Logical ops leave C and V untouched.
  assign flag_we = ((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) &&
                   Funct[0] && condex_q;
  assign cv_we   = (dp_alu_op == ALU_ADD) || (dp_alu_op == ALU_SUB);

  // Destination R15 means the write-back also loads the PC.
  assign pc_dest = (Rd == 4'b1111);

  // ---------------------------------------------------------------------------
  // State, flag and condition registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        condex_q <= cond_ex;
      end
      if (flag_we) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (cv_we) begin
          flags_q[1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb block gets a default first,
  // so no path through the case statements can infer a latch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;          // undefined class: NOP
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;           // unused encodings recover
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs: decoded from state_q, condex_q and the stable IR fields.
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        // PC+8 is computed here so R15 reads see the architectural value.
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condex_q;
        PCWrite   = condex_q & pc_dest;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = condex_q;
      end
      S_EXECUTER: begin
        ALUSrcB    = 2'b00;
        ALUControl = dp_alu_op;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_alu_op;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = condex_q & ~no_write;
        PCWrite   = condex_q & pc_dest;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condex_q;
      end
      default: ;
    endcase
  end

  // Field-derived selects do not depend on state.
  assign ImmSrc = Op;
  assign RegSrc = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};
  assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. Instructions are expanded
// into per-cycle rows of {inputs, expected controls}. Each row drives the
// inputs, pushes its expectation to a scoreboard queue, and pops and compares
// it once the outputs have settled. Reset behaviour is exercised in a
// hand-written sequence.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] alu;
  } ctl_t;

  typedef struct packed {
    ctl_t       ctl;
    logic [1:0] imm;
    logic [1:0] rsrc;
  } exp_t;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] flags;
    ctl_t       exp;
  } vec_t;

  localparam logic [3:0] EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
                         MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
                         HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
                         GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF;

`ifdef MCCTRL_CMP_EN
  localparam logic [2:0] CMP_ALU = 3'b001;
`else
  localparam logic [2:0] CMP_ALU = 3'b000;
`endif

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ctl_t mk(input logic [3:0] st, input logic pcw, adr, mw,
                              irw, rw, input logic [1:0] rs, input logic asa,
                              input logic [1:0] asb, input logic [2:0] alu);
    return {st, pcw, adr, mw, irw, rw, rs, asa, asb, alu};
  endfunction

  // Per-state expected controls, taken from the state-control table.
  function automatic ctl_t c_fetch();  return mk(0, 1,0,0,1,0, 2'b10, 1, 2'b10, 3'b000); endfunction
  function automatic ctl_t c_decode(); return mk(1, 0,0,0,0,0, 2'b10, 1, 2'b10, 3'b000); endfunction
  function automatic ctl_t c_memadr(); return mk(2, 0,0,0,0,0, 2'b00, 0, 2'b01, 3'b000); endfunction
  function automatic ctl_t c_memrd();  return mk(3, 0,1,0,0,0, 2'b00, 0, 2'b00, 3'b000); endfunction

  task automatic row(input logic [3:0] cond, input logic [1:0] op,
                     input logic [5:0] funct, input logic [3:0] rd,
                     input logic [3:0] flags, input ctl_t e);
    vec_t v;
    v.cond = cond; v.op = op; v.funct = funct; v.rd = rd;
    v.flags = flags; v.exp = e;
    tbl.push_back(v);
  endtask

  // Data-processing: FETCH, DECODE, EXECUTE(R/I), ALUWB.
  task automatic add_dp(input logic [3:0] cond, input logic i,
                        input logic [3:0] cmd, input logic s,
                        input logic [3:0] rd, input logic [3:0] flags,
                        input logic [2:0] alu, input logic rw, input logic pcw);
    logic [5:0] f;
    f = {i, cmd, s};
    row(cond, 2'b00, f, rd, flags, c_fetch());
    row(cond, 2'b00, f, rd, flags, c_decode());
    if (i) row(cond, 2'b00, f, rd, flags, mk(7, 0,0,0,0,0, 2'b00, 0, 2'b01, alu));
    else   row(cond, 2'b00, f, rd, flags, mk(6, 0,0,0,0,0, 2'b00, 0, 2'b00, alu));
    row(cond, 2'b00, f, rd, flags, mk(8, pcw,0,0,0,rw, 2'b00, 0, 2'b00, 3'b000));
  endtask

  // LDR: FETCH, DECODE, MEMADR, MEMREAD, MEMWB. ALUFlags noise must be ignored.
  task automatic add_ldr(input logic [3:0] cond, input logic [3:0] rd,
                         input logic rw, input logic pcw);
    row(cond, 2'b01, 6'b011001, rd, 4'hF, c_fetch());
    row(cond, 2'b01, 6'b011001, rd, 4'hF, c_decode());
    row(cond, 2'b01, 6'b011001, rd, 4'hF, c_memadr());
    row(cond, 2'b01, 6'b011001, rd, 4'hF, c_memrd());
    row(cond, 2'b01, 6'b011001, rd, 4'hF, mk(4, pcw,0,0,0,rw, 2'b01, 0, 2'b00, 3'b000));
  endtask

  task automatic add_str(input logic [3:0] cond, input logic mw);
    row(cond, 2'b01, 6'b011000, 4'd6, 4'hF, c_fetch());
    row(cond, 2'b01, 6'b011000, 4'd6, 4'hF, c_decode());
    row(cond, 2'b01, 6'b011000, 4'd6, 4'hF, c_memadr());
    row(cond, 2'b01, 6'b011000, 4'd6, 4'hF, mk(5, 0,1,mw,0,0, 2'b00, 0, 2'b00, 3'b000));
  endtask

  task automatic add_b(input logic [3:0] cond, input logic taken);
    row(cond, 2'b10, 6'b101010, 4'd0, 4'hF, c_fetch());
    row(cond, 2'b10, 6'b101010, 4'd0, 4'hF, c_decode());
    row(cond, 2'b10, 6'b101010, 4'd0, 4'hF, mk(9, taken,0,0,0,0, 2'b10, 0, 2'b01, 3'b000));
  endtask

  task automatic add_undef(input logic [3:0] cond);
    row(cond, 2'b11, 6'b000000, 4'd0, 4'hF, c_fetch());
    row(cond, 2'b11, 6'b000000, 4'd0, 4'hF, c_decode());
  endtask

  task automatic drive(input vec_t v);
    Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd; ALUFlags = v.flags;
  endtask

  // Drive one row, push its expectation, compare once settled, then advance.
  task automatic apply(input vec_t v, input int idx);
    exp_t e, got;
    drive(v);
    e.ctl  = v.exp;
    e.imm  = v.op;
    e.rsrc = {(v.op == 2'b01) && !v.funct[0], v.op == 2'b10};
    sb_q.push_back(e);
    #2;
    got.ctl  = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl};
    got.imm  = ImmSrc;
    got.rsrc = RegSrc;
    e = sb_q.pop_front();
    check($sformatf("row%0d state", idx), 32'(got.ctl.st), 32'(e.ctl.st));
    check($sformatf("row%0d controls", idx), 32'(got), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input int base);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], base + i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    Cond = 4'h0; Op = 2'b00; Funct = 6'h00; Rd = 4'h0; ALUFlags = 4'h0;
    repeat (2) @(posedge clk);
    #2;
    check("reset state", 32'(State), 32'd0);
    check("reset fetch ctl", 32'({IRWrite, PCWrite, ALUSrcA, ALUSrcB}), 32'b11110);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- Phase A: flags start at 0000 ----------------
    add_dp(AL, 1, 4'b0100, 0, 4'd3,  4'b0000, 3'b000, 1, 0);   // ADD imm
    add_ldr(AL, 4'd2, 1, 0);
    add_str(AL, 1);
    add_dp(AL, 0, 4'b0010, 1, 4'd4,  4'b0100, 3'b001, 1, 0);   // SUBS -> Z=1
    add_b(EQ, 1);
    add_b(NE, 0);
    add_undef(AL);
    add_dp(EQ, 0, 4'b0100, 0, 4'd15, 4'b0000, 3'b000, 1, 1);   // ADD PC, true
    add_dp(AL, 1, 4'b0000, 1, 4'd5,  4'b1011, 3'b010, 1, 0);   // ANDS: N=1 Z=0, C/V kept 0
    add_b(MI, 1);
    add_b(CS, 0);
    add_b(VS, 0);
    add_b(PL, 0);
    add_dp(EQ, 0, 4'b0100, 0, 4'd15, 4'b0000, 3'b000, 0, 0);   // ADD PC, false
    add_str(EQ, 0);
    add_ldr(EQ, 4'd15, 0, 0);
    add_ldr(AL, 4'd15, 1, 1);
    add_dp(EQ, 0, 4'b0010, 1, 4'd4,  4'b0100, 3'b001, 0, 0);   // SUBS failing cond: no flag load
    add_b(NE, 1);
    add_dp(AL, 0, 4'b1100, 0, 4'd1,  4'b0000, 3'b011, 1, 0);   // ORR
    add_dp(AL, 0, 4'b1101, 0, 4'd1,  4'b0000, 3'b000, 0, 0);   // unsupported cmd
    add_dp(NV, 1, 4'b0100, 0, 4'd1,  4'b0000, 3'b000, 0, 0);   // never
    add_b(NV, 0);
    add_dp(AL, 0, 4'b1010, 1, 4'd0,  4'b0110, CMP_ALU, 0, 0);  // CMP: Z=1 C=1
    add_b(HI, 0);
    add_b(LS, 1);
    add_b(GE, 1);
    add_b(LT, 0);
    add_b(GT, 0);
    add_b(LE, 1);
    add_b(CC, 0);
    add_b(VC, 1);
    add_b(AL, 1);
    run_table(0);

    // ---------------- Reset in the middle of EXECUTER ----------------
    tbl.delete();
    add_dp(AL, 0, 4'b0010, 1, 4'd4, 4'b0100, 3'b001, 1, 0);
    apply(tbl[0], 1000);
    apply(tbl[1], 1001);
    drive(tbl[2]);
    #2;
    check("pre-reset state", 32'(State), 32'd6);
    #1;
    reset = 1'b1;
    #1;
    check("mid-cycle reset state", 32'(State), 32'd0);
    check("reset fetch ctl", 32'({IRWrite, PCWrite, ALUSrcB}), 32'b1110);
    @(posedge clk);
    #1;
    check("held reset state", 32'(State), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- Phase B: flags must be cleared ----------------
    tbl.delete();
    add_b(EQ, 0);
    add_b(CS, 0);
    add_b(NE, 1);
    add_dp(AL, 1, 4'b0100, 0, 4'd7, 4'b0000, 3'b000, 1, 0);
    run_table(2000);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
